wf_dpbram_reader: RTL and testbench
===================================

WF_DPBRAM_READER -- requirements
Module: wf_dpbram_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, waveform sample width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, DPBRAM read-port address width (depth 2^ADDR_WIDTH).
REQ-003 SHALL have parameter RD_LATENCY, default 2, DPBRAM read latency in clocks (legal 1..4).
REQ-004 SHALL have port i_clk, input, 1, single clock for all logic.
REQ-005 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_wf_start, input, 1, single-cycle playback start pulse.
REQ-007 SHALL have port i_wf_stop, input, 1, single-cycle playback abort pulse.
REQ-008 SHALL have port i_wf_loop_en, input, 1, 1 = wrap to address 0 after the last sample.
REQ-009 SHALL have port i_wf_length, input, ADDR_WIDTH+1, sample count (1..2^ADDR_WIDTH).
REQ-010 SHALL have port i_wf_period, input, 32, clocks between successive fetches.
REQ-011 SHALL have port o_wf_read_en, output, 1, DPBRAM read enable.
REQ-012 SHALL have port o_wf_read_addr, output, ADDR_WIDTH, DPBRAM read address.
REQ-013 SHALL have port i_wf_read_data, input, DATA_WIDTH, DPBRAM read data.
REQ-014 SHALL have port o_wf_data, output, DATA_WIDTH, current output sample.
REQ-015 SHALL have port o_wf_data_valid, output, 1, one-cycle strobe per new sample.
REQ-016 SHALL have port o_wf_busy, output, 1, high while not IDLE.
REQ-017 SHALL have port o_wf_done, output, 1, one-cycle pulse at playback end.
REQ-018 SHALL have port o_wf_read_data_num, output, 32, samples delivered since last start.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN.
REQ-020 IDLE: i_wf_start with i_wf_length != 0 and i_wf_stop low -> RUN; length/period/loop latched at that edge; start with length 0 or with stop in the same cycle ignored.
REQ-021 Latched length > 2^ADDR_WIDTH SHALL clamp to 2^ADDR_WIDTH; latched period < RD_LATENCY+1 SHALL clamp to RD_LATENCY+1.
REQ-022 RUN: fetch in first RUN cycle, then every latched-period clocks; fetch = o_wf_read_en high one cycle with o_wf_read_addr = current address; address then increments.
REQ-023 Fetch at address length-1: loop_en latched 1 -> next address 0, stay RUN; else -> DRAIN.
REQ-024 Fetch issued in cycle T SHALL capture i_wf_read_data at end of cycle T+RD_LATENCY; o_wf_data updated and o_wf_data_valid high in cycle T+RD_LATENCY+1.
REQ-025 o_wf_data SHALL hold its last value between strobes and after playback ends.
REQ-026 i_wf_stop in RUN -> DRAIN; no further fetches; in-flight fetches still delivered.
REQ-027 DRAIN: wait until all in-flight fetches delivered, then o_wf_done high one cycle and -> IDLE.
REQ-028 i_wf_start outside IDLE SHALL be ignored; i_wf_stop in IDLE/DRAIN ignored.
REQ-029 o_wf_read_data_num SHALL clear to 0 on accepted start, +1 per o_wf_data_valid, saturate at 0xFFFFFFFF.
REQ-030 o_wf_read_en SHALL never assert outside RUN; o_wf_busy high in RUN and DRAIN.

Reset
REQ-031 i_rst SHALL force IDLE, abort in-flight fetches (no strobes after reset), and zero all outputs: o_wf_read_en, o_wf_read_addr, o_wf_data, o_wf_data_valid, o_wf_busy, o_wf_done, o_wf_read_data_num.
REQ-032 i_rst SHALL take priority over every other input in the same cycle.

Verification
REQ-033 BRAM model RD_LATENCY=2, mem[k]=k+0x100; start, length 4, period 5, loop 0 -> fetches at addr 0..3 every 5 clocks, valid 3 clocks after each fetch with 0x100..0x103, done one cycle after 4th valid, read_data_num=4.
REQ-034 Length 3, period 4, loop 1, stop after 7 fetches -> addresses 0,1,2,0,1,2,0; 7 strobes; done; read_data_num=7.
REQ-035 Period 1 with RD_LATENCY=2 -> fetch spacing 3 clocks (clamp).
REQ-036 Start with length 0 -> busy stays 0, no fetch; start during RUN -> no restart, count continues.
REQ-037 i_rst one cycle after a fetch -> no valid strobe follows, all outputs 0, next start runs from addr 0.
REQ-038 Length 1025 (ADDR_WIDTH 10), period 3 -> exactly 1024 fetches, last addr 1023, read_data_num=1024.

Source files
------------

// File: rtl/wf_dpbram_reader_if.sv
// Read port of the dual-port BRAM that holds the waveform samples.
// The reader drives enable/address and receives data RD_LATENCY clocks later.
interface wf_dpbram_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  o_wf_read_en;
  logic [ADDR_WIDTH-1:0] o_wf_read_addr;
  logic [DATA_WIDTH-1:0] i_wf_read_data;

  modport master (
    output o_wf_read_en,
    output o_wf_read_addr,
    input  i_wf_read_data
  );

  modport slave (
    input  o_wf_read_en,
    input  o_wf_read_addr,
    output i_wf_read_data
  );
endinterface

// File: rtl/wf_dpbram_reader.sv
// Waveform playback reader: fetches samples from a DPBRAM at a programmable
// period, optionally looping, and presents each returned sample with a strobe.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for an accepted start pulse
// ST_RUN   | issuing fetches every latched period
// ST_DRAIN | no more fetches; waiting for in-flight reads, then pulse done
module wf_dpbram_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wf_start,
  input  logic                  i_wf_stop,
  input  logic                  i_wf_loop_en,
  input  logic [ADDR_WIDTH:0]   i_wf_length,
  input  logic [31:0]           i_wf_period,
  wf_dpbram_reader_if.master    bram,
  output logic [DATA_WIDTH-1:0] o_wf_data,
  output logic                  o_wf_data_valid,
  output logic                  o_wf_busy,
  output logic                  o_wf_done,
  output logic [31:0]           o_wf_read_data_num
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [31:0]         MIN_PERIOD = 32'(RD_LATENCY + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH:0]     len_q;
  logic [31:0]             period_q;
  logic                    loop_q;
  logic [ADDR_WIDTH-1:0]   addr_q;      // address of the next fetch
  logic [31:0]             tmr_q;       // clocks remaining until the next fetch
  logic                    rd_en_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [RD_LATENCY-1:0]   pipe_q;      // one bit per outstanding fetch, by age
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    valid_q;
  logic                    done_q;
  logic [31:0]             num_q;

  logic [ADDR_WIDTH:0]     len_d;
  logic [31:0]             period_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    last_fetch_d;
  logic                    in_flight_d;

  // Clamp the programmed length/period and work out the address sequencing.
  always_comb begin
    len_d        = (i_wf_length > MAX_LEN) ? MAX_LEN : i_wf_length;
    period_d     = (i_wf_period < MIN_PERIOD) ? MIN_PERIOD : i_wf_period;
    addr_d       = ({1'b0, addr_q} == len_q - (ADDR_WIDTH+1)'(1)) ? '0
                                                                   : addr_q + ADDR_WIDTH'(1);
    last_fetch_d = ({1'b0, rd_addr_q} == len_q - (ADDR_WIDTH+1)'(1));
    in_flight_d  = rd_en_q | (|pipe_q);
  end

  // Playback FSM, read pipeline tracking and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      period_q  <= '0;
      loop_q    <= 1'b0;
      addr_q    <= '0;
      tmr_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      pipe_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      num_q     <= '0;
    end else begin
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      pipe_q  <= (pipe_q << 1) | RD_LATENCY'(rd_en_q);

      if (pipe_q[RD_LATENCY-1]) begin
        data_q  <= bram.i_wf_read_data;
        valid_q <= 1'b1;
        if (num_q != '1) num_q <= num_q + 32'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (i_wf_start && !i_wf_stop && (i_wf_length != '0)) begin
            state_q   <= ST_RUN;
            len_q     <= len_d;
            period_q  <= period_d;
            loop_q    <= i_wf_loop_en;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            addr_q    <= (len_d == (ADDR_WIDTH+1)'(1)) ? '0 : ADDR_WIDTH'(1);
            tmr_q     <= period_d - 32'd1;
            num_q     <= '0;
          end
        end
        ST_RUN: begin
          // The period is always longer than one clock, so the last fetch
          // cycle never coincides with a timer expiry.
          if (i_wf_stop) begin
            state_q <= ST_DRAIN;
          end else if (rd_en_q && last_fetch_d && !loop_q) begin
            state_q <= ST_DRAIN;
          end else if (tmr_q == '0) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= addr_q;
            addr_q    <= addr_d;
            tmr_q     <= period_q - 32'd1;
          end else begin
            tmr_q <= tmr_q - 32'd1;
          end
        end
        ST_DRAIN: begin
          if (!in_flight_d) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bram.o_wf_read_en   = rd_en_q;
  assign bram.o_wf_read_addr = rd_addr_q;
  assign o_wf_data           = data_q;
  assign o_wf_data_valid     = valid_q;
  assign o_wf_busy           = (state_q != ST_IDLE);
  assign o_wf_done           = done_q;
  assign o_wf_read_data_num  = num_q;

endmodule

// File: tb/tb_wf_dpbram_reader.sv
// Bench for the waveform DPBRAM reader: a latency-2 BRAM model with
// mem[k] = k + 0x100, an event monitor, and expectations computed from the
// playback rules (fetch n at start+n*spacing, sample delivered 3 clocks later).
module tb_wf_dpbram_reader;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [AW:0]   length;
  logic [31:0]   period;
  logic [DW-1:0] wf_data;
  logic          wf_valid;
  logic          busy;
  logic          done;
  logic [31:0]   num;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int viol     = 0;

  int            fc[$];
  int            fa[$];
  int            vc[$];
  logic [DW-1:0] vd[$];
  int            dc[$];

  wf_dpbram_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bram_if ();

  wf_dpbram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RL)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_wf_start         (start),
    .i_wf_stop          (stop),
    .i_wf_loop_en       (loop_en),
    .i_wf_length        (length),
    .i_wf_period        (period),
    .bram               (bram_if),
    .o_wf_data          (wf_data),
    .o_wf_data_valid    (wf_valid),
    .o_wf_busy          (busy),
    .o_wf_done          (done),
    .o_wf_read_data_num (num)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage BRAM model; garbage when not read so a wrong capture point shows.
  logic [DW-1:0] stage1;
  always @(posedge clk) begin
    stage1 <= bram_if.o_wf_read_en ? DW'(bram_if.o_wf_read_addr) + 16'h0100 : DW'($urandom);
    bram_if.i_wf_read_data <= stage1;
  end

  always @(negedge clk) begin
    if (bram_if.o_wf_read_en) begin
      fc.push_back(cyc);
      fa.push_back(int'(bram_if.o_wf_read_addr));
    end
    if (wf_valid) begin
      vc.push_back(cyc);
      vd.push_back(wf_data);
    end
    if (done) dc.push_back(cyc);
    if (bram_if.o_wf_read_en && !busy) viol++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    fc.delete(); fa.delete(); vc.delete(); vd.delete(); dc.delete();
    viol = 0;
  endtask

  task automatic run_case(input int len, input int per, input bit lp, input int stop_after,
                          input bit poke);
    int lc, sp, n, t0, m;
    bit stopped, poked, got_done;
    clear_logs();
    lc = (len > 1024) ? 1024 : len;
    sp = (per < RL + 1) ? RL + 1 : per;
    n  = lp ? stop_after : ((stop_after != 0 && stop_after < lc) ? stop_after : lc);
    @(negedge clk); #1;
    length  = (AW+1)'(len);
    period  = 32'(per);
    loop_en = lp;
    start   = 1'b1;
    t0      = cyc + 1;
    stopped = 1'b0; poked = 1'b0; got_done = 1'b0;
    for (int g = 0; g < 20000 && !got_done; g++) begin
      @(negedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
      if (poke && !poked && fc.size() >= 1) begin
        start = 1'b1; length = 7; period = 50; poked = 1'b1;
      end
      if (stop_after != 0 && !stopped && fc.size() == stop_after) begin
        stop = 1'b1; stopped = 1'b1;
      end
      if (dc.size() != 0) got_done = 1'b1;
    end
    start = 1'b0;
    stop  = 1'b0;
    check("done_seen", 64'(got_done), 64'd1);
    repeat (6) @(negedge clk);
    #1;
    check("fetch_count", 64'(fc.size()), 64'(n));
    m = (fc.size() < n) ? fc.size() : n;
    for (int i = 0; i < m; i++) begin
      check("fetch_addr", 64'(fa[i]), 64'(i % lc));
      check("fetch_cycle", 64'(fc[i]), 64'(t0 + i * sp));
    end
    check("valid_count", 64'(vc.size()), 64'(n));
    m = (vc.size() < n) ? vc.size() : n;
    for (int i = 0; i < m; i++) begin
      check("valid_cycle", 64'(vc[i]), 64'(t0 + i * sp + RL + 1));
      check("valid_data", 64'(vd[i]), 64'((i % lc) + 256));
    end
    check("done_count", 64'(dc.size()), 64'd1);
    if (dc.size() > 0) check("done_cycle", 64'(dc[0]), 64'(t0 + (n - 1) * sp + RL + 2));
    check("data_num", 64'(num), 64'(n));
    check("busy_after", 64'(busy), 64'd0);
    check("data_hold", 64'(wf_data), 64'(((n - 1) % lc) + 256));
    check("read_en_outside_busy", 64'(viol), 64'd0);
  endtask

  initial begin
    int len, per, sa;
    bit lp, pk, seen;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; length = '0; period = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_read_en", 64'(bram_if.o_wf_read_en), 64'd0);
    check("rst_read_addr", 64'(bram_if.o_wf_read_addr), 64'd0);
    check("rst_data", 64'(wf_data), 64'd0);
    check("rst_valid", 64'(wf_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_num", 64'(num), 64'd0);
    rst = 1'b0;

    run_case(4, 5, 1'b0, 0, 1'b0);
    run_case(3, 4, 1'b1, 7, 1'b0);
    run_case(3, 1, 1'b0, 0, 1'b0);

    // Zero-length start and start-with-stop are both ignored.
    clear_logs();
    @(negedge clk); #1;
    length = 0; period = 4; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_fetches", 64'(fc.size()), 64'd0);
    @(negedge clk); #1;
    length = 3; start = 1'b1; stop = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; stop = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("startstop_busy", 64'(busy), 64'd0);
    check("startstop_fetches", 64'(fc.size()), 64'd0);

    run_case(5, 4, 1'b0, 0, 1'b1);

    // Reset one cycle after a fetch aborts the in-flight read.
    clear_logs();
    @(negedge clk); #1;
    length = 4; period = 5; loop_en = 1'b0; start = 1'b1;
    seen = 1'b0;
    for (int g = 0; g < 20 && !seen; g++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (fc.size() == 1) seen = 1'b1;
    end
    check("rst_case_first_fetch", 64'(seen), 64'd1);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check("mid_rst_read_en", 64'(bram_if.o_wf_read_en), 64'd0);
    check("mid_rst_read_addr", 64'(bram_if.o_wf_read_addr), 64'd0);
    check("mid_rst_data", 64'(wf_data), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_num", 64'(num), 64'd0);
    repeat (6) @(negedge clk);
    #1;
    check("mid_rst_no_valid", 64'(vc.size()), 64'd0);
    check("mid_rst_no_done", 64'(dc.size()), 64'd0);
    run_case(2, 3, 1'b0, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      len = int'($urandom_range(1, 6));
      per = int'($urandom_range(1, 7));
      lp  = 1'($urandom_range(0, 1));
      pk  = 1'($urandom_range(0, 1));
      if (lp) sa = int'($urandom_range(1, 10));
      else    sa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, len)) : 0;
      run_case(len, per, lp, sa, pk);
    end

    run_case(1025, 3, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
